// File: rtl/ic_restore_ctrl_if.sv
// Command port of ic_restore_ctrl: valid/ready handshake plus the operands sampled at accept.
interface ic_restore_ctrl_if #(
  parameter int N = 7,
  parameter int R = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [R-1:0] cmd_rep;
  logic [N:0]   load_val;
  logic         cmd_abort;

  modport master (
    output cmd_valid, cmd_op, cmd_rep, load_val, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rep, load_val, cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/ic_restore_ctrl.sv
// Sequencing controller for one ic incrementer/decrementer: owns the count register,
// runs repeated INC/DEC steps through ic and keeps a LIFO of saved counts for RESTORE.
module ic_restore_ctrl #(
  parameter int N     = 7,
  parameter int DEPTH = 4,
  parameter int R     = 4
) (
  input  logic                clk,
  input  logic                rst,
  ic_restore_ctrl_if.slave    cmd,
  output logic [N:0]          dp_count,
  output logic                dp_enable,
  output logic                dp_decInc,
  output logic                dp_oneOrTwo,
  input  logic [N:0]          dp_next,
  output logic [N:0]          count,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                aborted,
  output logic                stack_full,
  output logic                stack_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_INC1    = 3'b001;
  localparam logic [2:0] OP_INC2    = 3'b010;
  localparam logic [2:0] OP_DEC1    = 3'b011;
  localparam logic [2:0] OP_DEC2    = 3'b100;
  localparam logic [2:0] OP_SAVE    = 3'b101;
  localparam logic [2:0] OP_RESTORE = 3'b110;
  localparam logic [2:0] OP_LOAD    = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, stateNext;
  logic [N:0]    countReg, countNext;
  logic [R-1:0]  rem, remNext;
  logic [PW-1:0] sp, spNext;
  logic          decReg, decNext;
  logic          twoReg, twoNext;
  logic          doneNext, errNext, abortedNext;
  logic          push;
  logic [N:0]    stack [2**AW];
  logic [AW-1:0] wrIdx, rdIdx;

  assign wrIdx = AW'(sp);
  assign rdIdx = AW'(sp - PW'(1));

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);
  assign count         = countReg;
  assign dp_count      = countReg;
  // Outside RUN the ic sits in buffer mode, so dp_next simply mirrors count.
  assign dp_enable     = (state == RUN);
  assign dp_decInc     = (state == RUN) & decReg;
  assign dp_oneOrTwo   = (state == RUN) & twoReg;

  always_comb begin
    stateNext   = state;
    countNext   = countReg;
    remNext     = rem;
    spNext      = sp;
    decNext     = decReg;
    twoNext     = twoReg;
    doneNext    = 1'b0;
    errNext     = 1'b0;
    abortedNext = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_NOP: doneNext = 1'b1;
            OP_LOAD: begin
              countNext = cmd.load_val;
              doneNext  = 1'b1;
            end
            OP_SAVE: begin
              doneNext = 1'b1;
              if (sp != PW'(DEPTH)) begin
                push   = 1'b1;
                spNext = sp + PW'(1);
              end else begin
                errNext = 1'b1;
              end
            end
            OP_RESTORE: begin
              doneNext = 1'b1;
              if (sp != '0) begin
                countNext = stack[rdIdx];
                spNext    = sp - PW'(1);
              end else begin
                errNext = 1'b1;
              end
            end
            default: begin
              // INC1/INC2/DEC1/DEC2: latch the step shape; count moves only in RUN.
              stateNext = RUN;
              remNext   = (cmd.cmd_rep == '0) ? R'(1) : cmd.cmd_rep;
              decNext   = (cmd.cmd_op == OP_DEC1) || (cmd.cmd_op == OP_DEC2);
              twoNext   = (cmd.cmd_op == OP_INC2) || (cmd.cmd_op == OP_DEC2);
            end
          endcase
        end
      end
      RUN: begin
        if (cmd.cmd_abort) begin
          stateNext   = IDLE;
          doneNext    = 1'b1;
          abortedNext = 1'b1;
        end else begin
          countNext = dp_next;
          remNext   = rem - R'(1);
          if (rem == R'(1)) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control and count register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      countReg    <= '0;
      rem         <= '0;
      sp          <= '0;
      decReg      <= 1'b0;
      twoReg      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      aborted     <= 1'b0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
    end else begin
      state       <= stateNext;
      countReg    <= countNext;
      rem         <= remNext;
      sp          <= spNext;
      decReg      <= decNext;
      twoReg      <= twoNext;
      done        <= doneNext;
      err         <= errNext;
      aborted     <= abortedNext;
      stack_full  <= (spNext == PW'(DEPTH));
      stack_empty <= (spNext == '0);
    end
  end

  // Snapshot storage is pure data; validity is tracked by sp alone.
  always_ff @(posedge clk) begin
    if (push) stack[wrIdx] <= countReg;
  end

endmodule

// File: tb/tb_ic_restore_ctrl.sv
// Directed self-checking bench for ic_restore_ctrl with a behavioural ic in the loop.
module tb_ic_restore_ctrl;

  localparam int N     = 7;
  localparam int DEPTH = 4;
  localparam int R     = 4;

  localparam logic [2:0] NOP = 3'b000, INC1 = 3'b001, INC2 = 3'b010, DEC1 = 3'b011,
                         DEC2 = 3'b100, SAVE = 3'b101, RESTORE = 3'b110, LOAD = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [N:0] dp_count, dp_next, count;
  logic       dp_enable, dp_decInc, dp_oneOrTwo;
  logic       busy, done, err, aborted, stack_full, stack_empty;

  int checks = 0;
  int errors = 0;

  ic_restore_ctrl_if #(.N(N), .R(R)) cmdIf ();

  ic_restore_ctrl #(.N(N), .DEPTH(DEPTH), .R(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmdIf.slave),
    .dp_count    (dp_count),
    .dp_enable   (dp_enable),
    .dp_decInc   (dp_decInc),
    .dp_oneOrTwo (dp_oneOrTwo),
    .dp_next     (dp_next),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .aborted     (aborted),
    .stack_full  (stack_full),
    .stack_empty (stack_empty)
  );

  always #5 clk = ~clk;

  // Behavioural ic: buffer when disabled, otherwise +/-1 or +/-2 modulo 256.
  always_comb begin
    if (!dp_enable)                 dp_next = dp_count;
    else if (dp_decInc)             dp_next = dp_count - (dp_oneOrTwo ? 8'd2 : 8'd1);
    else                            dp_next = dp_count + (dp_oneOrTwo ? 8'd2 : 8'd1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one command and return 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [R-1:0] rep, input logic [N:0] val);
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = op;
    cmdIf.cmd_rep   = rep;
    cmdIf.load_val  = val;
    @(posedge clk);
    #1;
    cmdIf.cmd_valid = 1'b0;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int maxCyc);
    int n = 0;
    while (!done && n < maxCyc) begin
      stepEdge();
      n++;
    end
    check("done_timeout", done, 1);
  endtask

  initial begin
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = NOP;
    cmdIf.cmd_rep   = '0;
    cmdIf.load_val  = '0;
    cmdIf.cmd_abort = 1'b0;

    // 1: reset state, then INC1 x3
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmdIf.cmd_ready, 1);
    check("rst_empty", stack_empty, 1);
    check("rst_full", stack_full, 0);
    check("rst_en", dp_enable, 0);
    @(negedge clk);
    rst = 1'b0;

    send(INC1, 4'd3, 8'h00);
    check("t1_busy0", busy, 1);
    check("t1_cnt0", count, 0);
    check("t1_en", dp_enable, 1);
    check("t1_ready", cmdIf.cmd_ready, 0);
    check("t1_ctl", {dp_decInc, dp_oneOrTwo}, 0);
    stepEdge();
    check("t1_cnt1", count, 1);
    check("t1_busy1", busy, 1);
    check("t1_done1", done, 0);
    stepEdge();
    check("t1_cnt2", count, 2);
    check("t1_busy2", busy, 1);
    stepEdge();
    check("t1_cnt3", count, 3);
    check("t1_busy3", busy, 0);
    check("t1_done", done, 1);
    stepEdge();
    check("t1_done_pulse", done, 0);

    // 2: wraps
    send(LOAD, 4'd0, 8'h01);
    check("t2_load_done", done, 1);
    check("t2_load", count, 8'h01);
    send(DEC2, 4'd1, 8'h00);
    check("t2_ctl", {dp_enable, dp_decInc, dp_oneOrTwo}, 3'b111);
    stepEdge();
    check("t2_wrap_dn", count, 8'hFF);
    check("t2_done", done, 1);
    check("t2_err", err, 0);
    send(LOAD, 4'd0, 8'hFE);
    send(INC2, 4'd2, 8'h00);
    waitDone(5);
    check("t2_wrap_up", count, 8'h02);

    // 3: save, step, restore
    send(LOAD, 4'd0, 8'h05);
    send(SAVE, 4'd0, 8'h00);
    check("t3_save_err", err, 0);
    check("t3_not_empty", stack_empty, 0);
    send(INC2, 4'd4, 8'h00);
    waitDone(8);
    check("t3_inc", count, 8'h0D);
    send(RESTORE, 4'd0, 8'h00);
    check("t3_restore", count, 8'h05);
    check("t3_empty", stack_empty, 1);
    check("t3_rst_err", err, 0);

    // 4: fill, overflow, drain LIFO, underflow
    for (int i = 0; i < DEPTH; i++) begin
      send(LOAD, 4'd0, 8'(8'h10 + i));
      send(SAVE, 4'd0, 8'h00);
      check("t4_save_err", err, 0);
    end
    check("t4_full", stack_full, 1);
    send(LOAD, 4'd0, 8'h77);
    send(SAVE, 4'd0, 8'h00);
    check("t4_ovf_err", err, 1);
    check("t4_ovf_done", done, 1);
    check("t4_ovf_full", stack_full, 1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      send(RESTORE, 4'd0, 8'h00);
      check("t4_lifo", count, 8'h10 + i);
      check("t4_pop_err", err, 0);
    end
    check("t4_empty", stack_empty, 1);
    send(RESTORE, 4'd0, 8'h00);
    check("t4_unf_err", err, 1);
    check("t4_unf_cnt", count, 8'h10);
    stepEdge();
    check("t4_err_pulse", err, 0);

    // 5: abort after 4 steps
    send(LOAD, 4'd0, 8'h00);
    send(INC1, 4'd10, 8'h00);
    repeat (4) stepEdge();
    check("t5_cnt4", count, 4);
    check("t5_busy", busy, 1);
    cmdIf.cmd_abort = 1'b1;
    stepEdge();
    cmdIf.cmd_abort = 1'b0;
    check("t5_cnt", count, 4);
    check("t5_aborted", aborted, 1);
    check("t5_done", done, 1);
    check("t5_idle", busy, 0);
    stepEdge();
    check("t5_abort_pulse", aborted, 0);

    // 6: async reset mid-run, then streamed NOPs
    send(LOAD, 4'd0, 8'h20);
    send(SAVE, 4'd0, 8'h00);
    send(DEC1, 4'd8, 8'h00);
    repeat (2) stepEdge();
    check("t6_cnt", count, 8'h1E);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cnt", count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_empty", stack_empty, 1);
    check("t6_rst_en", dp_enable, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_op    = NOP;
    stepEdge();
    for (int i = 0; i < 4; i++) begin
      check("t6_nop_done", done, 1);
      check("t6_nop_ready", cmdIf.cmd_ready, 1);
      stepEdge();
    end
    cmdIf.cmd_valid = 1'b0;
    check("t6_nop_cnt", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
